// File: rtl/definitions_pkg.sv
// Shared definitions for the canny line-buffer stage: default image geometry and border handling modes.
package definitions_pkg;

  localparam int IMAGE_WIDTH = 512;
  localparam int PIXEL_W     = 8;

  typedef enum logic {
    BORDER_ZERO      = 1'b0,
    BORDER_REPLICATE = 1'b1
  } border_mode_e;

endpackage

// File: rtl/lb_tap_mux.sv
// lb_tap_mux: combinational TAPS-wide read of the line store starting at the read column,
// substituting zero or the last pixel for taps that fall past the end of the line.
module lb_tap_mux
  import definitions_pkg::*;
#(
  parameter int DATA_W = PIXEL_W,
  parameter int LINE_W = IMAGE_WIDTH,
  parameter int TAPS   = 3,
  parameter int PTR_W  = $clog2(LINE_W)
) (
  input  logic [PTR_W-1:0]       i_rdPtr,
  input  border_mode_e           i_mode,
  input  logic [DATA_W-1:0]      i_line [LINE_W],
  output logic [TAPS*DATA_W-1:0] o_window
);

  // Two spare bits so rdPtr+k never wraps before it is compared against the line end.
  localparam int               COL_W    = PTR_W + 2;
  localparam logic [COL_W-1:0] LINE_END = COL_W'(LINE_W);

  logic [COL_W-1:0] w_col [TAPS];

  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      w_col[k] = {2'b00, i_rdPtr} + COL_W'(k);
    end
  end

  always_comb begin
    o_window = '0;
    for (int k = 0; k < TAPS; k++) begin
      if (w_col[k] < LINE_END) begin
        o_window[(TAPS-1-k)*DATA_W +: DATA_W] = i_line[w_col[k][PTR_W-1:0]];
      end else if (i_mode == BORDER_REPLICATE) begin
        o_window[(TAPS-1-k)*DATA_W +: DATA_W] = i_line[LINE_W-1];
      end
    end
  end

endmodule

// File: rtl/line_window_buffer.sv
// line_window_buffer: single-line pixel store with a TAPS-wide horizontal read window and flow control.
// Define LINE_WINDOW_BUFFER_ERR_FLAGS_EN to add sticky o_overflow / o_underflow flags.
module line_window_buffer
  import definitions_pkg::*;
#(
  parameter int DATA_W = PIXEL_W,
  parameter int LINE_W = IMAGE_WIDTH,
  parameter int TAPS   = 3,
  parameter int PTR_W  = $clog2(LINE_W)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      i_data,
  input  logic                   i_data_valid,
  output logic                   o_wr_ready,
  input  logic                   rd_enable,
  input  border_mode_e           i_border_mode,
  output logic [TAPS*DATA_W-1:0] o_data,
  output logic                   o_data_valid,
  output logic                   o_line_done,
  output logic [PTR_W:0]         o_fill_level
`ifdef LINE_WINDOW_BUFFER_ERR_FLAGS_EN
  ,
  output logic                   o_overflow,
  output logic                   o_underflow
`endif
);

  localparam logic [PTR_W-1:0] LAST_COL = PTR_W'(LINE_W - 1);
  localparam logic [PTR_W:0]   FILL_MAX = (PTR_W+1)'(LINE_W);
  localparam logic [PTR_W:0]   TAPS_N   = (PTR_W+1)'(TAPS);

  logic [DATA_W-1:0] r_line [LINE_W];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [PTR_W:0]    r_fill;
  logic              r_lineDone;
  logic              w_wrAccept;
  logic              w_rdAccept;
  logic [PTR_W:0]    w_remaining;
  logic [PTR_W:0]    w_needed;

  // Near the line end the window only needs the pixels left on this line, never the next one.
  always_comb begin
    w_remaining = FILL_MAX - {1'b0, r_rdPtr};
    w_needed    = (TAPS_N < w_remaining) ? TAPS_N : w_remaining;
  end

  assign o_wr_ready   = (r_fill != FILL_MAX);
  assign o_data_valid = (r_fill != '0) && (r_fill >= w_needed);
  assign w_wrAccept   = i_data_valid & o_wr_ready;
  assign w_rdAccept   = rd_enable & o_data_valid;
  assign o_fill_level = r_fill;
  assign o_line_done  = r_lineDone;

  always_ff @(posedge clk) begin
    if (w_wrAccept) begin
      r_line[r_wrPtr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_fill     <= '0;
      r_lineDone <= 1'b0;
    end else begin
      if (w_wrAccept) begin
        r_wrPtr <= (r_wrPtr == LAST_COL) ? '0 : r_wrPtr + 1'b1;
      end
      if (w_rdAccept) begin
        r_rdPtr <= (r_rdPtr == LAST_COL) ? '0 : r_rdPtr + 1'b1;
      end
      case ({w_wrAccept, w_rdAccept})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
      r_lineDone <= w_rdAccept && (r_rdPtr == LAST_COL);
    end
  end

`ifdef LINE_WINDOW_BUFFER_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (i_data_valid && !o_wr_ready) r_overflow <= 1'b1;
      if (rd_enable && !o_data_valid)  r_underflow <= 1'b1;
    end
  end

  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;
`else
  // Requests refused by flow control are dropped without any record.
`endif

  lb_tap_mux #(
    .DATA_W (DATA_W),
    .LINE_W (LINE_W),
    .TAPS   (TAPS),
    .PTR_W  (PTR_W)
  ) u_tapMux (
    .i_rdPtr  (r_rdPtr),
    .i_mode   (i_border_mode),
    .i_line   (r_line),
    .o_window (o_data)
  );

endmodule

// File: tb/tb_line_window_buffer.sv
// Bench for line_window_buffer (DATA_W=8, LINE_W=8, TAPS=3): directed line scenarios plus random traffic
// scored against a pixel-stream model; build with LINE_WINDOW_BUFFER_ERR_FLAGS_EN to also check the flags.
module tb_line_window_buffer;
  import definitions_pkg::*;

  localparam int DW = 8;
  localparam int LW = 8;
  localparam int TP = 3;
  localparam int PW = $clog2(LW);

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [DW-1:0]  i_data = '0;
  logic           i_data_valid = 1'b0;
  logic           rd_enable = 1'b0;
  border_mode_e   i_border_mode = BORDER_ZERO;
  logic           o_wr_ready;
  logic [TP*DW-1:0] o_data;
  logic           o_data_valid;
  logic           o_line_done;
  logic [PW:0]    o_fill_level;
`ifdef LINE_WINDOW_BUFFER_ERR_FLAGS_EN
  logic           o_overflow;
  logic           o_underflow;
`endif

  always #5 clk = ~clk;

  line_window_buffer #(.DATA_W(DW), .LINE_W(LW), .TAPS(TP)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_data        (i_data),
    .i_data_valid  (i_data_valid),
    .o_wr_ready    (o_wr_ready),
    .rd_enable     (rd_enable),
    .i_border_mode (i_border_mode),
    .o_data        (o_data),
    .o_data_valid  (o_data_valid),
    .o_line_done   (o_line_done),
    .o_fill_level  (o_fill_level)
`ifdef LINE_WINDOW_BUFFER_ERR_FLAGS_EN
    ,
    .o_overflow    (o_overflow),
    .o_underflow   (o_underflow)
`endif
  );

  typedef struct {
    logic valid;
    int   fill;
    logic wrReady;
    logic done;
    logic ovf;
    logic unf;
  } status_t;

  status_t          statQ[$];
  logic [TP*DW-1:0] winQ[$];

  // Model: the line as last written plus running counts of pixels written and read.
  logic [DW-1:0] mLine [LW];
  int   nWritten = 0;
  int   nRead = 0;
  logic mDone = 1'b0;
  logic mOvf = 1'b0;
  logic mUnf = 1'b0;
  int   testsRun = 0;
  int   testsFailed = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic modelValid();
    int col  = nRead % LW;
    int fill = nWritten - nRead;
    int need = (TP < LW - col) ? TP : LW - col;
    return (fill != 0) && (fill >= need);
  endfunction

  function automatic logic [TP*DW-1:0] expWindow(input border_mode_e m);
    logic [TP*DW-1:0] w;
    int col;
    for (int k = 0; k < TP; k++) begin
      col = nRead % LW + k;
      if (col < LW)                  w[(TP-1-k)*DW +: DW] = mLine[col];
      else if (m == BORDER_REPLICATE) w[(TP-1-k)*DW +: DW] = mLine[LW-1];
      else                           w[(TP-1-k)*DW +: DW] = '0;
    end
    return w;
  endfunction

  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic r, input border_mode_e m);
    status_t st;
    logic    valid;
    logic    wrReady;
    @(posedge clk);
    #2;
    i_data_valid  = v;
    i_data        = d;
    rd_enable     = r;
    i_border_mode = m;
    valid      = modelValid();
    wrReady    = (nWritten - nRead) < LW;
    st.valid   = valid;
    st.fill    = nWritten - nRead;
    st.wrReady = wrReady;
    st.done    = mDone;
    st.ovf     = mOvf;
    st.unf     = mUnf;
    statQ.push_back(st);
    if (r && valid) winQ.push_back(expWindow(m));
    mDone = r && valid && (nRead % LW == LW - 1);
    mOvf  = mOvf | (v && !wrReady);
    mUnf  = mUnf | (r && !valid);
    if (v && wrReady) begin
      mLine[nWritten % LW] = d;
      nWritten++;
    end
    if (r && valid) nRead++;
  endtask

  // Monitor: per-cycle status from the status queue, windows popped whenever the DUT accepts a read.
  always @(negedge clk) begin
    status_t st;
    logic [TP*DW-1:0] expWin;
    if (!rst && statQ.size() > 0) begin
      st = statQ.pop_front();
      checkOutput("data_valid", 64'(o_data_valid), 64'(st.valid));
      checkOutput("fill_level", 64'(o_fill_level), 64'(st.fill));
      checkOutput("wr_ready", 64'(o_wr_ready), 64'(st.wrReady));
      checkOutput("line_done", 64'(o_line_done), 64'(st.done));
`ifdef LINE_WINDOW_BUFFER_ERR_FLAGS_EN
      checkOutput("overflow", 64'(o_overflow), 64'(st.ovf));
      checkOutput("underflow", 64'(o_underflow), 64'(st.unf));
`endif
    end
    if (!rst && rd_enable && o_data_valid) begin
      if (winQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL window: DUT accepted a read with window %0h, expected no read", o_data);
      end else begin
        expWin = winQ.pop_front();
        checkOutput("window", 64'(o_data), 64'(expWin));
      end
    end
  end

  initial begin
    logic [TP*DW-1:0] exp1 [LW];
    logic [TP*DW-1:0] exp2 [LW];
    border_mode_e     m;
    exp1 = '{24'h010203, 24'h020304, 24'h030405, 24'h040506, 24'h050607, 24'h060708, 24'h070800, 24'h080000};
    exp2 = '{24'h010203, 24'h020304, 24'h030405, 24'h040506, 24'h050607, 24'h060708, 24'h070808, 24'h080808};
    m = BORDER_ZERO;

    #1 rst = 1'b1;
    #1;
    checkOutput("reset data_valid", 64'(o_data_valid), 64'd0);
    checkOutput("reset fill", 64'(o_fill_level), 64'd0);
    checkOutput("reset wr_ready", 64'(o_wr_ready), 64'd1);
    checkOutput("reset line_done", 64'(o_line_done), 64'd0);
    #1 rst = 1'b0;

    $display("[TB] zero-border line");
    for (int i = 0; i < LW; i++) applyStimulus(1'b1, DW'(i + 1), 1'b0, BORDER_ZERO);
    for (int i = 0; i < LW; i++) begin
      applyStimulus(1'b0, '0, 1'b1, BORDER_ZERO);
      #1 checkOutput("zero-border window", 64'(o_data), 64'(exp1[i]));
    end
    applyStimulus(1'b0, '0, 1'b0, BORDER_ZERO);
    #1 checkOutput("line_done pulse", 64'(o_line_done), 64'd1);
    applyStimulus(1'b0, '0, 1'b0, BORDER_ZERO);
    #1 checkOutput("line_done clears", 64'(o_line_done), 64'd0);

    $display("[TB] replicate-border line");
    for (int i = 0; i < LW; i++) applyStimulus(1'b1, DW'(i + 1), 1'b0, BORDER_REPLICATE);
    for (int i = 0; i < LW; i++) begin
      applyStimulus(1'b0, '0, 1'b1, BORDER_REPLICATE);
      #1 checkOutput("replicate window", 64'(o_data), 64'(exp2[i]));
    end

    $display("[TB] full store and dropped write");
    for (int i = 0; i < LW; i++) applyStimulus(1'b1, DW'(i + 1), 1'b0, BORDER_ZERO);
    applyStimulus(1'b0, '0, 1'b0, BORDER_ZERO);
    #1;
    checkOutput("full wr_ready", 64'(o_wr_ready), 64'd0);
    checkOutput("full fill", 64'(o_fill_level), 64'd8);
    applyStimulus(1'b1, 8'hAA, 1'b0, BORDER_ZERO);
    applyStimulus(1'b0, '0, 1'b1, BORDER_ZERO);
    #1 checkOutput("first read after drop", 64'(o_data), 64'h010203);
`ifdef LINE_WINDOW_BUFFER_ERR_FLAGS_EN
    checkOutput("overflow sticky", 64'(o_overflow), 64'd1);
`endif
    for (int i = 1; i < LW; i++) applyStimulus(1'b0, '0, 1'b1, BORDER_ZERO);

    $display("[TB] read refused at fill 2");
    applyStimulus(1'b1, 8'h11, 1'b0, BORDER_ZERO);
    applyStimulus(1'b1, 8'h22, 1'b0, BORDER_ZERO);
    applyStimulus(1'b0, '0, 1'b1, BORDER_ZERO);
    #1 checkOutput("short window not valid", 64'(o_data_valid), 64'd0);
    applyStimulus(1'b0, '0, 1'b0, BORDER_ZERO);
    #1 checkOutput("fill after refused read", 64'(o_fill_level), 64'd2);
`ifdef LINE_WINDOW_BUFFER_ERR_FLAGS_EN
    checkOutput("underflow sticky", 64'(o_underflow), 64'd1);
`endif

    $display("[TB] streaming across the line boundary");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, DW'(8'h33 + i), 1'b0, BORDER_ZERO);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b1, BORDER_ZERO);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, DW'(9 + i), 1'b1, BORDER_ZERO);
      #1 checkOutput("streaming fill", 64'(o_fill_level), 64'd3);
      if (i == 3) checkOutput("second line column 0", 64'(o_data), 64'h090A0B);
    end

    $display("[TB] asynchronous reset mid-line");
    applyStimulus(1'b1, 8'h55, 1'b0, BORDER_ZERO);
    applyStimulus(1'b1, 8'h66, 1'b0, BORDER_ZERO);
    applyStimulus(1'b0, '0, 1'b0, BORDER_ZERO);
    #1 checkOutput("fill before reset", 64'(o_fill_level), 64'd5);
    @(negedge clk);
    #1;
    i_data_valid = 1'b0;
    rd_enable    = 1'b0;
    rst          = 1'b1;
    #1;
    checkOutput("async reset data_valid", 64'(o_data_valid), 64'd0);
    checkOutput("async reset fill", 64'(o_fill_level), 64'd0);
    checkOutput("async reset wr_ready", 64'(o_wr_ready), 64'd1);
`ifdef LINE_WINDOW_BUFFER_ERR_FLAGS_EN
    checkOutput("async reset overflow", 64'(o_overflow), 64'd0);
    checkOutput("async reset underflow", 64'(o_underflow), 64'd0);
`endif
    nWritten = 0;
    nRead    = 0;
    mDone    = 1'b0;
    mOvf     = 1'b0;
    mUnf     = 1'b0;
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, DW'(i + 1), 1'b0, BORDER_ZERO);
    applyStimulus(1'b0, '0, 1'b0, BORDER_ZERO);
    #1;
    checkOutput("post-reset column 0", 64'(o_data), 64'h010203);
    checkOutput("post-reset valid", 64'(o_data_valid), 64'd1);

    $display("[TB] random traffic");
    for (int c = 0; c < 600; c++) begin
      if (nRead % LW == 0 && $urandom_range(0, 1) == 1)
        m = ($urandom_range(0, 1) == 1) ? BORDER_REPLICATE : BORDER_ZERO;
      if (c < 300)
        applyStimulus($urandom_range(0, 99) < 75, DW'($urandom), $urandom_range(0, 99) < 35, m);
      else
        applyStimulus($urandom_range(0, 99) < 40, DW'($urandom), $urandom_range(0, 99) < 80, m);
    end
    applyStimulus(1'b0, '0, 1'b0, m);
    applyStimulus(1'b0, '0, 1'b0, m);
    @(negedge clk);
    #1;
    checkOutput("window queue drained", 64'(winQ.size()), 64'd0);
    checkOutput("status queue drained", 64'(statQ.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
